reg_scoreboard: RTL and testbench

- Per-register pending-write tracker for the in-order RISC-V pipeline.
- Writer side: ID issues an instruction and the rd pending count increments. WB retires it and the count decrements.
- Reader side: ID rs1/rs2 are checked against the pending counts to produce the ID stall.
- Replaces per-stage rd comparison with stateful tracking, so pipelines of any depth and multi-cycle memory ops work.

---
 rtl/reg_scoreboard.sv | 105 ++++++++++
 tb/tb_reg_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-register pending-write tracker for an in-order pipeline.
//                ID increments the destination's pending count on issue, WB
//                decrements it on retire; source operands with a non-zero
//                pending count stall ID.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                id_valid,
   input  logic [4:0]          id_rs1,
   input  logic                id_en_rs1,
   input  logic [4:0]          id_rs2,
   input  logic                id_en_rs2,
   input  logic [4:0]          id_rd,
   input  logic                id_en_rd,
   input  logic                wb_valid,
   input  logic [4:0]          wb_rd,
   input  logic                wb_en_rd,
   output logic                data_hazard_ID,
   output logic                issue_fire,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                err_underflow
);

   // A counter at this value cannot accept another in-flight writer.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_REGS-1:0] rs1_hit;
   logic [NUM_REGS-1:0] rs2_hit;
   logic [NUM_REGS-1:0] rd_sat;
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic [NUM_REGS-1:0] uf_vec;
   logic                raw;
   logic                sat;
   logic                retire;

   // Hazards look only at registered counts, so an instruction whose rd equals
   // one of its sources never sees its own increment.
   assign raw            = id_valid && ((|rs1_hit) || (|rs2_hit));
   assign sat            = id_valid && id_en_rd && (|rd_sat);
   assign data_hazard_ID = raw || sat;
   assign issue_fire     = id_valid && !data_hazard_ID && !flush;
   assign retire         = wb_valid && wb_en_rd && (wb_rd != 5'd0) && !flush;

   genvar r;
   generate
      for (r = 0; r < NUM_REGS; r++) begin : g_reg
         if (r == 0) begin : g_zero
            // x0 is hardwired zero: never pending, never a hazard.
            assign busy_vec[r] = 1'b0;
            assign rs1_hit[r]  = 1'b0;
            assign rs2_hit[r]  = 1'b0;
            assign rd_sat[r]   = 1'b0;
            assign inc_vec[r]  = 1'b0;
            assign dec_vec[r]  = 1'b0;
            assign uf_vec[r]   = 1'b0;
         end else begin : g_track
            localparam logic [4:0] REG_IDX = 5'(r);
            logic [CNT_W-1:0] cnt;

            assign busy_vec[r] = (cnt != '0);
            assign rs1_hit[r]  = id_en_rs1 && (id_rs1 == REG_IDX) && busy_vec[r];
            assign rs2_hit[r]  = id_en_rs2 && (id_rs2 == REG_IDX) && busy_vec[r];
            assign rd_sat[r]   = (id_rd == REG_IDX) && (cnt == CNT_MAX);
            assign inc_vec[r]  = issue_fire && id_en_rd && (id_rd == REG_IDX);
            assign dec_vec[r]  = retire && (wb_rd == REG_IDX);
            assign uf_vec[r]   = dec_vec[r] && (cnt == '0);

            // Pending-write count: flush clears, simultaneous issue/retire cancel,
            // a retire at zero leaves the count at zero (flagged separately).
            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  cnt <= '0;
               end else if (flush) begin
                  cnt <= '0;
               end else if (inc_vec[r] && !dec_vec[r]) begin
                  cnt <= cnt + 1'b1;
               end else if (dec_vec[r] && !inc_vec[r] && (cnt != '0)) begin
                  cnt <= cnt - 1'b1;
               end
            end
         end
      end
   endgenerate

   // Sticky underflow flag; only reset clears it, flush leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_underflow <= 1'b0;
      end else if (|uf_vec) begin
         err_underflow <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Self-checking bench for reg_scoreboard; directed scenarios
//                followed by random traffic against an array-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

   localparam int NR   = 32;
   localparam int MAXC = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          id_valid;
   logic [4:0]    id_rs1;
   logic          id_en_rs1;
   logic [4:0]    id_rs2;
   logic          id_en_rs2;
   logic [4:0]    id_rd;
   logic          id_en_rd;
   logic          wb_valid;
   logic [4:0]    wb_rd;
   logic          wb_en_rd;
   logic          data_hazard_ID;
   logic          issue_fire;
   logic [NR-1:0] busy_vec;
   logic          err_underflow;

   int n_checks = 0;
   int n_errors = 0;

   int model_cnt [NR];
   bit model_err;

   reg_scoreboard #(.NUM_REGS(NR), .CNT_W(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .id_valid       (id_valid),
      .id_rs1         (id_rs1),
      .id_en_rs1      (id_en_rs1),
      .id_rs2         (id_rs2),
      .id_en_rs2      (id_en_rs2),
      .id_rd          (id_rd),
      .id_en_rd       (id_en_rd),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_en_rd       (wb_en_rd),
      .data_hazard_ID (data_hazard_ID),
      .issue_fire     (issue_fire),
      .busy_vec       (busy_vec),
      .err_underflow  (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_pending(input logic [4:0] r);
      return (r != 5'd0) && (model_cnt[r] != 0);
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] b = '0;
      for (int i = 1; i < NR; i++) b[i] = (model_cnt[i] != 0);
      return b;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NR; i++) model_cnt[i] = 0;
   endtask

   task automatic set_in(input bit v, input int rs1, input bit e1, input int rs2, input bit e2,
                         input int rd, input bit erd, input bit wv, input int wrd, input bit fl);
      id_valid  = v;
      id_rs1    = 5'(rs1);
      id_en_rs1 = e1;
      id_rs2    = 5'(rs2);
      id_en_rs2 = e2;
      id_rd     = 5'(rd);
      id_en_rd  = erd;
      wb_valid  = wv;
      wb_rd     = 5'(wrd);
      wb_en_rd  = wv;
      flush     = fl;
   endtask

   // One clock: compare DUT against the model at the falling edge, then
   // advance the model by what the rising edge should do.
   task automatic cycle(output bit fire_obs);
      bit haz, fire, ret;
      @(negedge clk);
      haz = id_valid && ((id_en_rs1 && model_pending(id_rs1)) ||
                         (id_en_rs2 && model_pending(id_rs2)) ||
                         (id_en_rd && id_rd != 5'd0 && model_cnt[id_rd] == MAXC));
      fire = id_valid && !haz && !flush;
      ret  = wb_valid && wb_en_rd && wb_rd != 5'd0 && !flush;
      check("hazard", 32'(data_hazard_ID), 32'(haz));
      check("fire",   32'(issue_fire),     32'(fire));
      check("busy",   busy_vec,            model_busy());
      check("err",    32'(err_underflow),  32'(model_err));
      fire_obs = issue_fire;
      @(posedge clk);
      if (flush) begin
         model_clear();
      end else begin
         if (ret && model_cnt[wb_rd] == 0 && !(fire && id_en_rd && id_rd == wb_rd))
            model_err = 1;
         else if (ret && model_cnt[wb_rd] == 0)
            model_err = 1;
         if (fire && id_en_rd && id_rd != 5'd0) model_cnt[id_rd] += 1;
         if (ret) model_cnt[wb_rd] = (model_cnt[wb_rd] > 0) ? model_cnt[wb_rd] - 1 : 0;
      end
      #1;
   endtask

   task automatic idle(input int n);
      bit f;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) cycle(f);
   endtask

   initial begin
      bit f;
      model_clear();
      model_err = 0;
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy_vec, 32'd0);
      check("rst_err",  32'(err_underflow), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Issue x5, read it back while pending, retire at the fourth cycle.
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cycle(f);
      set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); cycle(f);
      check("t1_stall", 32'(data_hazard_ID), 32'd1);
      cycle(f);
      set_in(1, 5, 1, 0, 0, 0, 0, 1, 5, 0); cycle(f);
      set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); cycle(f);
      check("t1_go", 32'(f), 32'd1);

      // Saturate x7, fourth writer stalls until a retire frees a slot.
      set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      cycle(f); cycle(f); cycle(f);
      cycle(f); check("t2_sat", 32'(f), 32'd0);
      set_in(1, 0, 0, 0, 0, 7, 1, 1, 7, 0); cycle(f);
      check("t2_sat_ret", 32'(f), 32'd0);
      set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle(f);
      check("t2_fire", 32'(f), 32'd1);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); repeat (3) cycle(f);

      // Issue and retire of x9 in the same cycle with count 1.
      set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); cycle(f);
      set_in(1, 0, 0, 0, 0, 9, 1, 1, 9, 0); cycle(f);
      idle(1);
      check("t3_busy9", 32'(busy_vec[9]), 32'd1);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); cycle(f);

      // x0 is never tracked.
      set_in(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
      repeat (4) cycle(f);
      check("t4_busy", busy_vec, 32'd0);

      // Flush with a concurrent retire and issue.
      set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cycle(f);
      set_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); cycle(f);
      set_in(1, 0, 0, 0, 0, 6, 1, 1, 3, 1); cycle(f);
      check("t5_fire", 32'(f), 32'd0);
      idle(1);
      check("t5_busy", busy_vec, 32'd0);

      // Retire x12 at zero, then asynchronous reset mid-cycle.
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 12, 0); cycle(f);
      set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); cycle(f);
      check("t6_err", 32'(err_underflow), 32'd1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 reset = 1'b1;
      #1;
      check("t6_async_err",  32'(err_underflow), 32'd0);
      check("t6_async_busy", busy_vec, 32'd0);
      model_clear();
      model_err = 0;
      #1 reset = 1'b0;

      // Random traffic on a small register window to provoke hazards.
      for (int k = 0; k < 400; k++) begin
         int wr;
         wr = $urandom_range(0, 7);
         if ($urandom_range(0, 9) < 8) begin
            for (int t = 0; t < 8; t++) begin
               int c = $urandom_range(1, 7);
               if (model_cnt[c] != 0) begin wr = c; break; end
            end
         end
         set_in($urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 2) != 0, wr,
                $urandom_range(0, 29) == 0);
         wb_en_rd = $urandom_range(0, 5) != 0;
         cycle(f);
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
